ddr_wdata_pack_fifo: RTL and testbench

//  Synchronous packing FIFO between a narrow write-data stream (user/NPU side) and the wide DDR3 write-data path.

---
 rtl/ddr_wdata_pack_fifo_if.sv | 25 ++
 rtl/ddr_wdata_pack_fifo.sv | 105 ++++++++++
 tb/tb_ddr_wdata_pack_fifo.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_wdata_pack_fifo_if.sv
// Handshake bundle for the DDR write-data packing FIFO: narrow beat input side and wide packed-word output side.
interface ddr_wdata_pack_fifo_if #(
  parameter int IN_WIDTH   = 64,
  parameter int PACK_RATIO = 4
);
  logic                           s_valid;
  logic [IN_WIDTH-1:0]            s_data;
  logic                           s_last;
  logic                           s_ready;
  logic                           m_valid;
  logic [IN_WIDTH*PACK_RATIO-1:0] m_data;
  logic [PACK_RATIO-1:0]          m_keep;
  logic                           m_last;
  logic                           m_ready;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last
  );
endinterface

// File: rtl/ddr_wdata_pack_fifo.sv
// Packs PACK_RATIO narrow beats into one wide DDR write word (with keep/last), buffers words in an
// inferred RAM and presents them through a registered valid/ready output stage.
module ddr_wdata_pack_fifo #(
  parameter int IN_WIDTH    = 64,
  parameter int PACK_RATIO  = 4,
  parameter int DEPTH_WIDTH = 8,
  parameter int AF_MARGIN   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   soft_clr,
  ddr_wdata_pack_fifo_if.slave   bus,
  output logic [DEPTH_WIDTH:0]   level,
  output logic                   almost_full
);

  localparam int OUT_W  = IN_WIDTH * PACK_RATIO;
  localparam int RAM_W  = OUT_W + PACK_RATIO + 1;
  localparam int DEPTH  = 1 << DEPTH_WIDTH;
  localparam int LANE_W = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;
  localparam logic [DEPTH_WIDTH:0] AF_LEVEL = (DEPTH_WIDTH+1)'(DEPTH - AF_MARGIN);
  localparam logic [LANE_W-1:0]    TOP_LANE = LANE_W'(PACK_RATIO - 1);

  logic [LANE_W-1:0]      lane_cnt;
  logic [OUT_W-1:0]       partial;
  logic [OUT_W-1:0]       wr_data;
  logic [PACK_RATIO-1:0]  wr_keep;
  logic                   s_fire;
  logic                   commit;
  logic                   rd_en;
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [DEPTH_WIDTH:0]   level_nxt;
  logic [RAM_W-1:0]       mem [DEPTH];

  // s_ready depends only on registered state plus the clear/reset inputs, never on s_valid
  assign bus.s_ready = rst_n & ~almost_full & ~soft_clr;
  assign s_fire      = bus.s_valid & bus.s_ready;
  assign commit      = s_fire & ((lane_cnt == TOP_LANE) | bus.s_last);
  assign rd_en       = (level != '0) & (~bus.m_valid | bus.m_ready) & ~soft_clr;
  assign level_nxt   = level + (DEPTH_WIDTH+1)'(commit) - (DEPTH_WIDTH+1)'(rd_en);

  // Current beat merged into the held lanes; lanes above lane_cnt are still zero in partial
  always_comb begin
    wr_data = partial;
    wr_keep = '0;
    for (int unsigned k = 0; k < PACK_RATIO; k++) begin
      if (k == 32'(lane_cnt)) wr_data[k*IN_WIDTH +: IN_WIDTH] = bus.s_data;
      if (k <= 32'(lane_cnt)) wr_keep[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt <= '0;
      partial  <= '0;
    end else if (soft_clr || commit) begin
      lane_cnt <= '0;
      partial  <= '0;
    end else if (s_fire) begin
      lane_cnt <= lane_cnt + 1'b1;
      partial  <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[wr_ptr] <= {bus.s_last, wr_keep, wr_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      almost_full <= 1'b0;
    end else if (soft_clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + DEPTH_WIDTH'(commit);
      rd_ptr      <= rd_ptr + DEPTH_WIDTH'(rd_en);
      level       <= level_nxt;
      almost_full <= (level_nxt >= AF_LEVEL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_keep  <= '0;
      bus.m_last  <= 1'b0;
    end else if (soft_clr) begin
      bus.m_valid <= 1'b0;
    end else if (rd_en) begin
      bus.m_valid <= 1'b1;
      {bus.m_last, bus.m_keep, bus.m_data} <= mem[rd_ptr];
    end else if (bus.m_ready) begin
      bus.m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr_wdata_pack_fifo.sv
// Directed bench for ddr_wdata_pack_fifo: packing, latency, backpressure, soft clear, reset, and a PACK_RATIO=1 instance.
module tb_ddr_wdata_pack_fifo;
  localparam int IW = 64;
  localparam int R  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic soft_clr = 1'b0;
  logic soft_clr1 = 1'b0;
  logic [DW:0] level;
  logic almost_full;
  logic [4:0] level1;
  logic af1;

  ddr_wdata_pack_fifo_if #(.IN_WIDTH(IW), .PACK_RATIO(R)) bus ();
  ddr_wdata_pack_fifo_if #(.IN_WIDTH(16), .PACK_RATIO(1)) bus1 ();

  ddr_wdata_pack_fifo #(.IN_WIDTH(IW), .PACK_RATIO(R), .DEPTH_WIDTH(DW), .AF_MARGIN(4)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .bus(bus), .level(level), .almost_full(almost_full)
  );

  ddr_wdata_pack_fifo #(.IN_WIDTH(16), .PACK_RATIO(1), .DEPTH_WIDTH(4), .AF_MARGIN(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr1), .bus(bus1), .level(level1), .almost_full(af1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] d;
    logic [3:0]   k;
    logic         l;
  } word_t;

  word_t exp_q[$];
  logic [16:0] q6[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int first_mv = -1;
  int cyc_b4 = 0;
  logic s_acc = 1'b0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t mk(input logic [63:0] l0, l1, l2, l3, input logic [3:0] k, input logic l);
    word_t w;
    w.d = {l3, l2, l1, l0};
    w.k = k;
    w.l = l;
    return w;
  endfunction

  // Called at a negedge with inputs already set; returns at the next negedge
  task automatic step();
    #1;
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) check("spurious_word", 256'(exp_q.size()), 256'(1));
      else begin
        word_t w;
        w = exp_q.pop_front();
        check("m_data", bus.m_data, w.d);
        check("m_keep", 256'(bus.m_keep), 256'(w.k));
        check("m_last", 256'(bus.m_last), 256'(w.l));
      end
    end
    if (bus.m_valid && first_mv < 0) first_mv = cyc;
    s_acc = bus.s_valid && bus.s_ready;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [63:0] d, input logic last);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    for (int i = 0; i < 500; i++) begin
      step();
      if (s_acc) break;
    end
    if (!s_acc) check("send_timeout", 256'(s_acc), 256'(1));
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic drain();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) step();
    idle(2);
    check("drain_empty", 256'(exp_q.size()), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int stall;
    int max_lvl;
    bus.s_valid = 0; bus.s_data = '0; bus.s_last = 0; bus.m_ready = 0;
    bus1.s_valid = 0; bus1.s_data = '0; bus1.s_last = 0; bus1.m_ready = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_s_ready", 256'(bus.s_ready), 256'(0));
    check("rst_m_valid", 256'(bus.m_valid), 256'(0));
    check("rst_m_data", bus.m_data, 256'(0));
    check("rst_m_keep", 256'(bus.m_keep), 256'(0));
    check("rst_m_last", 256'(bus.m_last), 256'(0));
    check("rst_level", 256'(level), 256'(0));
    check("rst_af", 256'(almost_full), 256'(0));
    rst_n = 1'b1;
    #1;
    check("post_rst_s_ready", 256'(bus.s_ready), 256'(1));
    @(negedge clk);

    // 1) two full words, latency of first word
    bus.m_ready = 1'b1;
    first_mv = -1;
    exp_q.push_back(mk(64'h1, 64'h2, 64'h3, 64'h4, 4'hF, 1'b0));
    exp_q.push_back(mk(64'h5, 64'h6, 64'h7, 64'h8, 4'hF, 1'b0));
    for (int i = 1; i <= 8; i++) begin
      send(64'(i), 1'b0);
      if (i == 4) cyc_b4 = cyc - 1;
    end
    idle(6);
    check("t1_latency", 256'(first_mv), 256'(cyc_b4 + 2));
    check("t1_q_empty", 256'(exp_q.size()), 256'(0));

    // 2) short packet then a full word starting at lane 0
    exp_q.push_back(mk(64'hA, 64'hB, 64'hC, 64'h0, 4'h7, 1'b1));
    exp_q.push_back(mk(64'hD, 64'hE, 64'hF, 64'h10, 4'hF, 1'b0));
    send(64'hA, 1'b0); send(64'hB, 1'b0); send(64'hC, 1'b1);
    send(64'hD, 1'b0); send(64'hE, 1'b0); send(64'hF, 1'b0); send(64'h10, 1'b0);
    idle(6);
    check("t2_q_empty", 256'(exp_q.size()), 256'(0));

    // 4) simultaneous commit and read at level 1
    bus.m_ready = 1'b0;
    exp_q.push_back(mk(64'h41, 64'h42, 64'h43, 64'h44, 4'hF, 1'b0));
    exp_q.push_back(mk(64'h45, 64'h46, 64'h47, 64'h48, 4'hF, 1'b0));
    exp_q.push_back(mk(64'h49, 64'h4A, 64'h4B, 64'h4C, 4'hF, 1'b0));
    for (int i = 0; i < 8; i++) send(64'h41 + 64'(i), 1'b0);
    idle(3);
    check("t4_level_pre", 256'(level), 256'(1));
    check("t4_mvalid_pre", 256'(bus.m_valid), 256'(1));
    send(64'h49, 1'b0); send(64'h4A, 1'b0); send(64'h4B, 1'b0);
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 64'h4C;
    step();
    bus.s_valid = 1'b0;
    check("t4_accept", 256'(s_acc), 256'(1));
    check("t4_level_same", 256'(level), 256'(1));
    check("t4_mvalid_1", 256'(bus.m_valid), 256'(1));
    step();
    check("t4_mvalid_2", 256'(bus.m_valid), 256'(1));
    check("t4_level_0", 256'(level), 256'(0));
    idle(3);
    check("t4_q_empty", 256'(exp_q.size()), 256'(0));

    // 3) backpressure until almost_full, then full drain in order
    bus.m_ready = 1'b0;
    beats = 0;
    stall = 0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 1500 && stall < 4; i++) begin
      bus.s_data = 64'h1000 + 64'(beats);
      step();
      if (s_acc) begin
        beats++;
        stall = 0;
        if (beats % 4 == 0)
          exp_q.push_back(mk(64'h1000 + 64'(beats-4), 64'h1000 + 64'(beats-3),
                             64'h1000 + 64'(beats-2), 64'h1000 + 64'(beats-1), 4'hF, 1'b0));
      end else stall++;
    end
    bus.s_valid = 1'b0;
    check("t3_beats", 256'(beats), 256'(1012));
    check("t3_level_af", 256'(level), 256'(252));
    check("t3_s_ready", 256'(bus.s_ready), 256'(0));
    check("t3_almost_full", 256'(almost_full), 256'(1));
    drain();
    check("t3_level_end", 256'(level), 256'(0));
    check("t3_s_ready_end", 256'(bus.s_ready), 256'(1));

    // 5) soft clear with queued words and two held lanes
    bus.m_ready = 1'b0;
    for (int i = 0; i < 46; i++) send(64'h2000 + 64'(i), 1'b0);
    idle(2);
    check("t5_level_pre", 256'(level), 256'(10));
    soft_clr = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 64'hDEAD;
    #1;
    check("t5_s_ready_clr", 256'(bus.s_ready), 256'(0));
    step();
    soft_clr = 1'b0;
    bus.s_valid = 1'b0;
    check("t5_level_clr", 256'(level), 256'(0));
    check("t5_mvalid_clr", 256'(bus.m_valid), 256'(0));
    exp_q.push_back(mk(64'h31, 64'h32, 64'h33, 64'h0, 4'h7, 1'b1));
    send(64'h31, 1'b0); send(64'h32, 1'b0); send(64'h33, 1'b1);
    drain();

    // Async reset mid-transfer
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(64'h50 + 64'(i), 1'b0);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mvalid", 256'(bus.m_valid), 256'(0));
    check("arst_level", 256'(level), 256'(0));
    check("arst_keep", 256'(bus.m_keep), 256'(0));
    check("arst_s_ready", 256'(bus.s_ready), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 6) PACK_RATIO=1 instance, random traffic then drain
    max_lvl = 0;
    for (int i = 0; i < 3100; i++) begin
      if (i < 3000) begin
        bus1.s_valid = ($urandom_range(0, 3) != 0);
        bus1.s_data  = 16'($urandom);
        bus1.s_last  = ($urandom_range(0, 7) == 0);
        bus1.m_ready = ($urandom_range(0, 2) != 0);
      end else begin
        bus1.s_valid = 1'b0;
        bus1.m_ready = 1'b1;
      end
      #1;
      if (int'(level1) > max_lvl) max_lvl = int'(level1);
      if (bus1.m_valid && bus1.m_ready) begin
        if (q6.size() == 0) check("r1_spurious", 256'(q6.size()), 256'(1));
        else begin
          logic [16:0] e;
          e = q6.pop_front();
          check("r1_data", 256'(bus1.m_data), 256'(e[15:0]));
          check("r1_keep", 256'(bus1.m_keep), 256'(1));
          check("r1_last", 256'(bus1.m_last), 256'(e[16]));
        end
      end
      if (bus1.s_valid && bus1.s_ready) q6.push_back({bus1.s_last, bus1.s_data});
      @(negedge clk);
    end
    check("r1_q_empty", 256'(q6.size()), 256'(0));
    check("r1_level_end", 256'(level1), 256'(0));
    check("r1_no_overflow", 256'(max_lvl <= 16), 256'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
